// File: rtl/mpc_pkg.sv
// mpc_pkg: shared definitions for the multi-port crossbar arbiters.
//   PORTNUM     - default number of requesting channels
//   ID_W        - width of a channel index
//   arb_state_e - per-output-port arbiter state
package mpc_pkg;
  localparam int PORTNUM = 16;
  localparam int ID_W    = $clog2(PORTNUM);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req    [N-1:0]   request vector
//   ptr    [IDW-1:0] highest-priority index for this pick (must be < N)
//   winner [IDW-1:0] first set request at or after ptr, wrapping
//   valid            any request set
module rr_arbiter #(
  parameter int N   = 16,
  parameter int IDW = 4
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] winner,
  output logic           valid
);
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    idx    = '0;
    // Scan N positions starting at ptr; first hit wins.
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
      idx = sum[IDW-1:0];
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end
endmodule

// File: rtl/port_arbiter.sv
// port_arbiter: one output port's arbiter. Channels pulse i_req; one winner
// gets o_resp, every other requester gets o_nresp one cycle later. The winner
// holds the port until its eop beat (i_eop & i_data_vld), then the port frees.
//   i_clk, i_rst_n            clock, async active-low reset
//   i_req/i_data_vld/i_eop    per-channel request pulse, data strobe, eop
//   o_resp/o_nresp            grant / reject pulses (registered)
//   o_ready                   port idle
//   o_grant_id                current or last winner
//   o_pkt_done/o_timeout      release pulses (normal / forced)
// Optional: define ARB_TIMEOUT_EN to force release after TIMEOUT idle BUSY
// cycles; otherwise o_timeout is tied low and no counter exists.
module port_arbiter #(
  parameter int PORTNUM = mpc_pkg::PORTNUM,
  parameter int TIMEOUT = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [PORTNUM-1:0]         i_req,
  input  logic [PORTNUM-1:0]         i_data_vld,
  input  logic [PORTNUM-1:0]         i_eop,
  output logic [PORTNUM-1:0]         o_resp,
  output logic [PORTNUM-1:0]         o_nresp,
  output logic                       o_ready,
  output logic [$clog2(PORTNUM)-1:0] o_grant_id,
  output logic                       o_pkt_done,
  output logic                       o_timeout
);
  import mpc_pkg::*;

  localparam int IDW = $clog2(PORTNUM);

  arb_state_e           state_q, state_d;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       win;
  logic                 win_vld;
  logic [PORTNUM-1:0]   win_oh;
  logic                 grant_go, rel_eop, rel_to;
  logic                 own_vld, own_eop;

  rr_arbiter #(.N(PORTNUM), .IDW(IDW)) u_rr (
    .req    (i_req),
    .ptr    (rr_ptr),
    .winner (win),
    .valid  (win_vld)
  );

  assign win_oh  = {{(PORTNUM-1){1'b0}}, 1'b1} << win;
  assign own_vld = i_data_vld[o_grant_id];
  assign own_eop = i_eop[o_grant_id];

`ifdef ARB_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        to_q;
  logic        to_hit;

  // A beat from the owner in the last allowed cycle still counts as activity.
  assign to_hit = (idle_cnt == 16'(TIMEOUT-1)) && !own_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                idle_cnt <= '0;
    else if (state_q == S_GRANT)                 idle_cnt <= '0;
    else if (state_q == S_BUSY && own_vld)       idle_cnt <= '0;
    else if (state_q == S_BUSY)                  idle_cnt <= idle_cnt + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) to_q <= 1'b0;
    else          to_q <= rel_to;
  end
  assign o_timeout = to_q;
`else
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_go = 1'b0;
    rel_eop  = 1'b0;
    rel_to   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_go = 1'b1;
          state_d  = S_GRANT;
        end
      end
      S_GRANT: state_d = S_BUSY;
      S_BUSY: begin
        if (own_eop && own_vld) begin
          rel_eop = 1'b1;
          state_d = S_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (to_hit) begin
          rel_to  = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Every sampled request is answered next cycle: rejected by default,
  // granted only for the winner of an IDLE-cycle pick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr     <= '0;
      o_resp     <= '0;
      o_nresp    <= '0;
      o_ready    <= 1'b1;
      o_grant_id <= '0;
      o_pkt_done <= 1'b0;
    end else begin
      o_resp     <= '0;
      o_nresp    <= i_req;
      o_ready    <= (state_d == S_IDLE);
      o_pkt_done <= rel_eop;
      if (grant_go) begin
        o_resp     <= win_oh;
        o_nresp    <= i_req & ~win_oh;
        o_grant_id <= win;
        rr_ptr     <= (win == IDW'(PORTNUM-1)) ? '0 : win + 1'b1;
      end
    end
  end
endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 SHALL have parameter PORTNUM, default 16, meaning the number of requesting channels (one channel_req per input port).
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning the number of idle BUSY cycles before forced release (used only under ARB_TIMEOUT_EN).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port i_req, input, PORTNUM bits: bit c is channel c's single-cycle request pulse for this output port.
REQ-006 SHALL have port i_data_vld, input, PORTNUM bits: bit c is channel c's data-valid strobe.
REQ-007 SHALL have port i_eop, input, PORTNUM bits: bit c is channel c's end-of-packet flag.
REQ-008 SHALL have port o_resp, output, PORTNUM bits: one-hot grant pulse to the winning channel.
REQ-009 SHALL have port o_nresp, output, PORTNUM bits: reject pulse to every other requesting channel.
REQ-010 SHALL have port o_ready, output, 1 bit: port free to accept a request.
REQ-011 SHALL have port o_grant_id, output, $clog2(PORTNUM) bits: index of the current or last winner.
REQ-012 SHALL have port o_pkt_done, output, 1 bit: single-cycle pulse on packet release.
REQ-013 SHALL have port o_timeout, output, 1 bit: single-cycle pulse on forced release.

Function
REQ-014 SHALL implement states S_IDLE, S_GRANT and S_BUSY.
REQ-015 In S_IDLE, if i_req!=0, SHALL pick a round-robin winner starting from rr_ptr, register o_grant_id, and go to S_GRANT.
REQ-016 On entering S_GRANT, o_resp SHALL equal 1<<winner for exactly one cycle, and o_nresp SHALL equal the sampled i_req with the winner bit cleared, for the same cycle.
REQ-017 Latency from i_req to o_resp/o_nresp SHALL be exactly 1 cycle; every request pulse receives exactly one of the two responses.
REQ-018 Any i_req bit sampled in S_GRANT or S_BUSY SHALL produce the corresponding o_nresp bit on the next cycle, and no o_resp.
REQ-019 rr_ptr SHALL load winner+1, modulo PORTNUM (wraps PORTNUM-1 to 0), on each grant.
REQ-020 S_GRANT SHALL always advance to S_BUSY after one cycle.
REQ-021 In S_BUSY, i_eop[grant_id]&i_data_vld[grant_id] SHALL cause S_IDLE next cycle with an o_pkt_done pulse.
REQ-022 In S_BUSY, i_eop and i_data_vld from non-granted channels SHALL be ignored.
REQ-023 A request in the same cycle as the releasing eop SHALL get o_nresp; requests are accepted only from the first S_IDLE cycle.
REQ-024 o_ready SHALL be 1 only in S_IDLE, registered.
REQ-025 o_resp and o_nresp SHALL never both have the same bit set.

Reset
REQ-026 While i_rst_n=0: state=S_IDLE, rr_ptr=0, o_resp=0, o_nresp=0, o_ready=1, o_grant_id=0, o_pkt_done=0, o_timeout=0.
REQ-027 Reset asserted mid-packet SHALL abandon the grant with no o_pkt_done pulse.

Configuration
REQ-028 Macro ARB_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entering S_BUSY and on every i_data_vld[grant_id], and SHALL increment otherwise.
REQ-029 When that counter reaches TIMEOUT-1, the block SHALL pulse o_timeout, return to S_IDLE, and not pulse o_pkt_done.
REQ-030 Macro ARB_TIMEOUT_EN undefined: o_timeout SHALL be tied 0, no counter SHALL exist, and S_BUSY SHALL be left only on eop.

Structure
REQ-031 Shared package mpc_pkg SHALL hold PORTNUM, the arbiter state enum, and the ID width constant.
REQ-032 Sub-module rr_arbiter SHALL be combinational: given request vector and pointer, it outputs winner index and valid; the FSM stays in port_arbiter.

Verification
REQ-033 The bench SHALL cover: i_req=16'h0001 in S_IDLE -> next cycle o_resp=16'h0001, o_nresp=0, o_ready=0.
REQ-034 The bench SHALL cover: rr_ptr=0, i_req=16'h8004 -> o_resp=16'h0004, o_nresp=16'h8000, rr_ptr=3.
REQ-035 The bench SHALL cover: grant ch5, i_req=16'h0002 during S_BUSY -> o_nresp=16'h0002, o_resp=0.
REQ-036 The bench SHALL cover: grant ch5, i_eop[5]&i_data_vld[5] with i_req=16'h0010 same cycle -> o_pkt_done=1, o_nresp=16'h0010; request next cycle -> granted.
REQ-037 The bench SHALL cover: grant ch15, rr_ptr wraps to 0; then i_req=16'hFFFF -> winner ch0.
REQ-038 The bench SHALL cover, with ARB_TIMEOUT_EN and TIMEOUT=8: grant, no i_data_vld for 8 cycles -> o_timeout pulse, o_ready=1; mid-packet reset -> all outputs at reset values.
